// File: rtl/i2s_tx_serializer.sv
// I2S transmit stage: derives MCLK/SCK/LRCK from the system clock and
// serialises one latched 16-bit left/right pair per 512-clk frame.
module i2s_tx_serializer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] audio_in_left,
  input  logic [DATA_W-1:0] audio_in_right,
  input  logic              mute,
  output logic              sample_req,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic              audio_sdin
);

  logic [8:0]        cnt;
  logic [DATA_W-1:0] l_s;
  logic [DATA_W-1:0] r_s;
  logic              req;
  logic              sdin;
  logic              sdin_next;
  logic [4:0]        g;
  logic [3:0]        bidx;
  logic              slot_end;
  logic              latch;

  assign g        = cnt[8:4];
  assign bidx     = ~g[3:0];
  assign slot_end = (cnt[3:0] == 4'hF);
  assign latch    = (cnt == 9'h1FF);

  // Bit for the slot that starts after this edge; slot 31 -> 0 sends
  // the old right LSB, captured before the latch overwrites r_s.
  always_comb begin
    sdin_next = 1'b0;
    unique case (1'b1)
      (g == 5'd31): sdin_next = r_s[0];
      (g[4] == 1'b0): sdin_next = l_s[bidx];
      default: sdin_next = r_s[bidx];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      l_s  <= '0;
      r_s  <= '0;
      req  <= 1'b0;
      sdin <= 1'b0;
    end else begin
      cnt <= cnt + 9'd1;
      req <= (cnt == 9'h1FE);
      if (slot_end) sdin <= sdin_next;
      if (latch) begin
        l_s <= mute ? '0 : audio_in_left;
        r_s <= mute ? '0 : audio_in_right;
      end
    end
  end

  assign sample_req = req;
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];
  assign audio_sdin = sdin;

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Stage that feeds the speaker output pins.
- Derives the Pmod I2S DAC clocks (MCLK, LRCK, SCK) from the 100 MHz system clock.
- Latches a 16-bit left/right sample pair once per frame and shifts it out MSB-first in I2S format on SDIN.
- Requests the next sample pair from the upstream tone/note generator with a one-cycle strobe.

Parameters:
- DATA_W, 16, bits per channel slot; fixed at 16 by the frame layout, present for documentation only.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- audio_in_left  input  16  left sample, two's complement
- audio_in_right  input  16  right sample, two's complement
- mute  input  1  when 1 at latch time, the latched pair is forced to 0
- sample_req  output  1  one-cycle strobe; inputs are sampled on the rising edge that ends this cycle
- audio_mclk  output  1  master clock, clk/4
- audio_lrck  output  1  word select, clk/512; 0 = left, 1 = right
- audio_sck  output  1  serial bit clock, clk/16
- audio_sdin  output  1  serial data

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - cnt=0; shadow regs L_s=R_s=0; prev_r0=0.
  - audio_sdin=0, sample_req=0.
  - mclk=sck=lrck=0.
  - Applies mid-frame too: the frame restarts cleanly at cnt=0 after release.
- Free-running 9-bit counter cnt: +1 every clk, wraps 511->0.
  - audio_mclk=cnt[1]
  - audio_sck=cnt[3]
  - audio_lrck=cnt[8]
  - All three are registered bits, so there is no combinational glitch.
- Slot index g=cnt[8:4], range 0..31, each slot = 16 clk.
  - Slot boundaries coincide with SCK falling edges (cnt[3]: 1->0).
  - LRCK edges also fall on slot boundaries.
- sample_req=1 exactly during cycles where cnt==511; 0 otherwise.
- Latch on the rising edge ending cnt==511:
  - If mute=0: L_s<=audio_in_left, R_s<=audio_in_right.
  - If mute=1: L_s<=0, R_s<=0.
  - Same edge: prev_r0<=old R_s[0].
- Input changes at any other time have no effect on the frame in progress.
- SDIN mapping, standard I2S with one-SCK delay after the LRCK edge:
  - g=0: prev_r0 (LSB of the previous right word)
  - g=1..16: L_s[16-g] (MSB at g=1, L_s[0] at g=16)
  - g=17..31: R_s[32-g] (R_s[15] at g=17 ... R_s[1] at g=31)
  - R_s[0] is emitted in the next frame's g=0.
- audio_sdin is registered and changes only on clk edges where cnt[3:0] goes 15->0. It is stable for the full SCK period, so the DAC samples it on the SCK rising edge mid-slot.
- Latency: an input pair presented during sample_req has its left MSB on SDIN 16 clk after the latch edge (slot g=1).
- Simultaneous events:
  - The latch edge and the g=31->0 data update occur on the same edge.
  - Slot g=0 must output the old R_s[0], captured into prev_r0 before the overwrite.
- No backpressure. Upstream must present valid data in the sample_req cycle. If it does not, whatever is on the inputs is sent.

Test Plan:
1. Reset & clocks: assert rst_n=0 mid-run -> all outputs 0 within the same cycle. Release -> mclk period 40 ns, sck 160 ns, lrck 5120 ns, 50% duty. sample_req pulses once per 512 clk, at cnt==511.
2. Serial pattern: left=16'hA5F0, right=16'h0F0F held at the latch. Next frame, SDIN bits sampled on SCK rising edges for g=1..16 = 1010_0101_1111_0000. For g=17..31 = 0000_1111_0000_111; following frame's g=0 = 1.
3. Mid-frame input change: change inputs to 16'hFFFF/16'hFFFF at cnt==200 -> the current frame still serialises the previously latched pair. The new values appear only after the next sample_req.
4. Mute: mute=1 during a sample_req with left=16'h7FFF -> the next frame's g=1..31 are all 0. g=0 still carries the prior R_s[0].
5. Reset mid-frame: pulse rst_n low at cnt==300 with nonzero data -> sdin=0 immediately. After release, the first frame outputs all zeros until the first latch, and sample_req first appears 512 clk after release.
